// File: rtl/riscv_consts.sv
// rtl/riscv_consts.sv - shared RV32I core constants
package riscv_consts;
    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;
    localparam int              INSTR_BYTES      = 4;
endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - in-order fetch queue: entries are allocated on request,
// filled on response and popped by decode; flush collapses all pointers onto tail.
module fetch_buffer
    import riscv_consts::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_i,
    input  logic [XLEN-1:0]        alloc_pc_i,
    input  logic                   fill_i,
    input  logic [XLEN-1:0]        fill_instr_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic                   head_valid_o,
    output logic [XLEN-1:0]        head_pc_o,
    output logic [XLEN-1:0]        head_instr_o,
    output logic [$clog2(DEPTH):0] alloc_cnt_o,
    output logic [$clog2(DEPTH):0] pending_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   fill_q, fill_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [DEPTH-1:0] filled_q;
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] instr_q [DEPTH];

    logic [AW-1:0] head_idx, fill_idx, tail_idx;
    assign head_idx = head_q[AW-1:0];
    assign fill_idx = fill_q[AW-1:0];
    assign tail_idx = tail_q[AW-1:0];

    always_comb begin
        head_d = head_q;
        fill_d = fill_q;
        tail_d = tail_q;
        if (flush_i) begin
            head_d = tail_q;
            fill_d = tail_q;
        end else begin
            if (alloc_i) tail_d = tail_q + PW'(1);
            if (fill_i)  fill_d = fill_q + PW'(1);
            if (pop_i)   head_d = head_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q   <= '0;
            fill_q   <= '0;
            tail_q   <= '0;
            filled_q <= '0;
        end else begin
            head_q <= head_d;
            fill_q <= fill_d;
            tail_q <= tail_d;
            // fill and alloc never target the same slot: that would need a full queue
            if (fill_i && !flush_i)  filled_q[fill_idx] <= 1'b1;
            if (alloc_i && !flush_i) filled_q[tail_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_i && !flush_i) pc_q[tail_idx]    <= alloc_pc_i;
        if (fill_i && !flush_i)  instr_q[fill_idx] <= fill_instr_i;
    end

    assign head_valid_o  = (head_q != tail_q) && filled_q[head_idx];
    assign head_pc_o     = pc_q[head_idx];
    assign head_instr_o  = instr_q[head_idx];
    assign alloc_cnt_o   = tail_q - head_q;
    assign pending_cnt_o = tail_q - fill_q;
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch: PC, imem request/response handshakes,
// redirect flush with a drop counter for responses still owed to the old stream.
module fetch_stage
    import riscv_consts::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            io_imem_req_valid,
    input  logic            io_imem_req_ready,
    output logic [XLEN-1:0] io_imem_req_addr,
    input  logic            io_imem_resp_valid,
    input  logic [XLEN-1:0] io_imem_resp_data,
    input  logic            io_redirect_valid,
    input  logic [XLEN-1:0] io_redirect_target,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic [XLEN-1:0] io_out_instr,
    output logic [XLEN-1:0] io_out_pc
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   alloc_cnt, pending_cnt;
    logic [PW:0]     used;
    logic            credit, req_fire, resp_drop, fill, pop;

    assign used      = {1'b0, alloc_cnt} + {1'b0, drop_q};
    assign credit    = used < (PW+1)'(DEPTH);
    assign io_imem_req_valid = credit && !io_redirect_valid;
    assign io_imem_req_addr  = pc_q;
    assign req_fire  = io_imem_req_valid && io_imem_req_ready;
    assign resp_drop = drop_q != '0;
    assign fill      = io_imem_resp_valid && !resp_drop && !io_redirect_valid;
    assign pop       = io_out_valid && io_out_ready;

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (io_redirect_valid) begin
            pc_d = {io_redirect_target[XLEN-1:2], 2'b00};
            // every old-stream response still in flight must be dropped, minus one arriving now
            drop_d = drop_q + pending_cnt - PW'(io_imem_resp_valid);
        end else begin
            if (req_fire) pc_d = pc_q + XLEN'(INSTR_BYTES);
            if (io_imem_resp_valid && resp_drop) drop_d = drop_q - PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    always @(posedge clk) begin
        if (!reset) assert (!(io_imem_resp_valid && drop_q == '0 && pending_cnt == '0));
    end

    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk           (clk),
        .reset         (reset),
        .alloc_i       (req_fire),
        .alloc_pc_i    (pc_q),
        .fill_i        (fill),
        .fill_instr_i  (io_imem_resp_data),
        .pop_i         (pop),
        .flush_i       (io_redirect_valid),
        .head_valid_o  (io_out_valid),
        .head_pc_o     (io_out_pc),
        .head_instr_o  (io_out_instr),
        .alloc_cnt_o   (alloc_cnt),
        .pending_cnt_o (pending_cnt)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with an in-order memory model
module tb_fetch_stage;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_imem_req_valid, io_imem_req_ready;
    logic [31:0] io_imem_req_addr;
    logic        io_imem_resp_valid;
    logic [31:0] io_imem_resp_data;
    logic        io_redirect_valid;
    logic [31:0] io_redirect_target;
    logic        io_out_valid, io_out_ready;
    logic [31:0] io_out_instr, io_out_pc;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .io_imem_req_valid  (io_imem_req_valid),
        .io_imem_req_ready  (io_imem_req_ready),
        .io_imem_req_addr   (io_imem_req_addr),
        .io_imem_resp_valid (io_imem_resp_valid),
        .io_imem_resp_data  (io_imem_resp_data),
        .io_redirect_valid  (io_redirect_valid),
        .io_redirect_target (io_redirect_target),
        .io_out_valid       (io_out_valid),
        .io_out_ready       (io_out_ready),
        .io_out_instr       (io_out_instr),
        .io_out_pc          (io_out_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc, last_due, lat;
    bit          mem_rdy, out_rdy, redir;
    logic [31:0] redir_tgt;
    bit          obs_req_valid, obs_req_fire, obs_out_valid, obs_out_fire, obs_resp, obs_redir;
    logic [31:0] obs_addr, obs_pc, obs_instr, obs_tgt;
    logic [31:0] m_req_pc, m_out_pc;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // One clock cycle: enter at negedge, drive, sample, leave at the next negedge.
    task automatic tick();
        io_imem_resp_valid = 1'b0;
        io_imem_resp_data  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            io_imem_resp_valid = 1'b1;
            io_imem_resp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        io_imem_req_ready  = mem_rdy;
        io_out_ready       = out_rdy;
        io_redirect_valid  = redir;
        io_redirect_target = redir_tgt;
        #1;
        obs_req_valid = io_imem_req_valid;
        obs_req_fire  = io_imem_req_valid && io_imem_req_ready;
        obs_addr      = io_imem_req_addr;
        obs_out_valid = io_out_valid;
        obs_out_fire  = io_out_valid && io_out_ready;
        obs_pc        = io_out_pc;
        obs_instr     = io_out_instr;
        obs_resp      = io_imem_resp_valid;
        obs_redir     = redir;
        obs_tgt       = redir_tgt;
        if (obs_req_fire) begin
            if (cyc + lat > last_due) last_due = cyc + lat;
            mq.push_back('{addr: io_imem_req_addr, due: last_due});
        end
        @(posedge clk);
        @(negedge clk);
        redir = 1'b0;
        cyc++;
    endtask

    // Program-order model: the request stream and the decode stream both walk pc+4 from the
    // last reset or redirect target.
    task automatic model_adv();
        if (obs_req_fire) m_req_pc = m_req_pc + 32'd4;
        if (obs_out_fire) m_out_pc = m_out_pc + 32'd4;
        if (obs_redir) begin
            m_req_pc = {obs_tgt[31:2], 2'b00};
            m_out_pc = m_req_pc;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        io_imem_req_ready = 1'b0; io_imem_resp_valid = 1'b0; io_imem_resp_data = '0;
        io_redirect_valid = 1'b0; io_redirect_target = '0; io_out_ready = 1'b0;
        mem_rdy = 0; out_rdy = 0; redir = 0; redir_tgt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        cyc = 0; last_due = 0;
        m_req_pc = RST_PC; m_out_pc = RST_PC;
    endtask

    task automatic test_reset();
        int first_out;
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (io_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", io_out_valid); end
        n_cmp++; if (io_imem_req_addr !== RST_PC) begin n_bad++; $display("FAIL reset_pc: got %h expected %h", io_imem_req_addr, RST_PC); end
        do_reset();
        lat = 1; mem_rdy = 1; out_rdy = 1;
        first_out = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) begin
                n_cmp++; if (obs_req_valid !== 1'b1) begin n_bad++; $display("FAIL reset_first_req: got %b expected 1", obs_req_valid); end
            end
            n_cmp++;
            if (!obs_req_fire || obs_addr !== m_req_pc) begin n_bad++; $display("FAIL reset_req_addr c%0d: fire %b addr %h expected %h", i, obs_req_fire, obs_addr, m_req_pc); end
            if (obs_out_fire && first_out < 0) first_out = i;
            if (i >= 2) begin
                n_cmp++;
                if (!obs_out_fire || obs_pc !== m_out_pc || obs_instr !== mem_word(m_out_pc))
                    begin n_bad++; $display("FAIL reset_stream c%0d: fire %b pc %h instr %h expected pc %h", i, obs_out_fire, obs_pc, obs_instr, m_out_pc); end
            end
            model_adv();
        end
        n_cmp++; if (first_out != 2) begin n_bad++; $display("FAIL first_out_cycle: got %0d expected 2", first_out); end
    endtask

    task automatic test_backpressure();
        int nreq, nout, nreq2;
        logic [31:0] first_new;
        do_reset();
        lat = 1; mem_rdy = 1; out_rdy = 0; nreq = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_req_fire) nreq++;
            model_adv();
        end
        n_cmp++; if (nreq != DEPTH) begin n_bad++; $display("FAIL full_req_count: got %0d expected %0d", nreq, DEPTH); end
        n_cmp++; if (obs_req_valid !== 1'b0) begin n_bad++; $display("FAIL full_req_valid: got %b expected 0", obs_req_valid); end
        out_rdy = 1; nout = 0; nreq2 = 0; first_new = 'x;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (obs_out_fire) begin
                n_cmp++;
                if (obs_pc !== m_out_pc || obs_instr !== mem_word(m_out_pc))
                    begin n_bad++; $display("FAIL drain_order: pc %h instr %h expected pc %h", obs_pc, obs_instr, m_out_pc); end
                nout++;
            end
            if (obs_req_fire) begin
                if (nreq2 == 0) first_new = obs_addr;
                nreq2++;
            end
            model_adv();
        end
        n_cmp++; if (nout < DEPTH) begin n_bad++; $display("FAIL drain_count: got %0d expected >= %0d", nout, DEPTH); end
        n_cmp++; if (first_new !== 32'h10) begin n_bad++; $display("FAIL resume_addr: got %h expected 00000010", first_new); end
    endtask

    task automatic test_redirect();
        int   nout;
        logic [31:0] first_pc;
        do_reset();
        lat = 3; mem_rdy = 1; out_rdy = 1;
        repeat (2) begin tick(); model_adv(); end
        redir = 1; redir_tgt = 32'h103;
        tick();
        n_cmp++; if (obs_req_valid !== 1'b0) begin n_bad++; $display("FAIL redir_suppress: got %b expected 0", obs_req_valid); end
        model_adv();
        tick();
        n_cmp++; if (!obs_req_fire || obs_addr !== 32'h100) begin n_bad++; $display("FAIL redir_addr: fire %b addr %h expected 00000100", obs_req_fire, obs_addr); end
        model_adv();
        nout = 0; first_pc = 'x;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (obs_out_fire) begin
                if (nout == 0) first_pc = obs_pc;
                n_cmp++;
                if (obs_pc !== m_out_pc || obs_instr !== mem_word(m_out_pc))
                    begin n_bad++; $display("FAIL redir_stream: pc %h instr %h expected pc %h", obs_pc, obs_instr, m_out_pc); end
                nout++;
            end
            model_adv();
        end
        n_cmp++; if (first_pc !== 32'h100) begin n_bad++; $display("FAIL redir_first_pc: got %h expected 00000100", first_pc); end
    endtask

    task automatic test_collide();
        int   nout;
        logic [31:0] first_pc;
        do_reset();
        lat = 1; mem_rdy = 1; out_rdy = 1;
        repeat (6) begin tick(); model_adv(); end
        redir = 1; redir_tgt = 32'h2000;
        tick();
        n_cmp++; if (obs_resp !== 1'b1) begin n_bad++; $display("FAIL collide_resp_present: got %b expected 1", obs_resp); end
        n_cmp++;
        if (!obs_out_fire || obs_pc !== m_out_pc)
            begin n_bad++; $display("FAIL collide_handshake: fire %b pc %h expected pc %h", obs_out_fire, obs_pc, m_out_pc); end
        model_adv();
        nout = 0; first_pc = 'x;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_out_fire) begin
                if (nout == 0) first_pc = obs_pc;
                n_cmp++;
                if (obs_pc !== m_out_pc || obs_instr !== mem_word(m_out_pc))
                    begin n_bad++; $display("FAIL collide_stream: pc %h instr %h expected pc %h", obs_pc, obs_instr, m_out_pc); end
                nout++;
            end
            model_adv();
        end
        n_cmp++; if (first_pc !== 32'h2000) begin n_bad++; $display("FAIL collide_first_pc: got %h expected 00002000", first_pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] addrs [3];
        int nreq;
        do_reset();
        lat = 2; mem_rdy = 1; out_rdy = 1;
        redir = 1; redir_tgt = 32'hFFFF_FFF9;
        tick(); model_adv();
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_req_fire && nreq < 3) begin addrs[nreq] = obs_addr; nreq++; end
            if (obs_out_fire) begin
                n_cmp++;
                if (obs_pc !== m_out_pc || obs_instr !== mem_word(m_out_pc))
                    begin n_bad++; $display("FAIL wrap_stream: pc %h instr %h expected pc %h", obs_pc, obs_instr, m_out_pc); end
            end
            model_adv();
        end
        n_cmp++;
        if (nreq != 3 || addrs[0] !== 32'hFFFF_FFF8 || addrs[1] !== 32'hFFFF_FFFC || addrs[2] !== 32'h0)
            begin n_bad++; $display("FAIL wrap_addrs: %h %h %h expected fffffff8 fffffffc 00000000", addrs[0], addrs[1], addrs[2]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat = 1; mem_rdy = 1; out_rdy = 0;
        repeat (8) begin tick(); model_adv(); end
        n_cmp++; if (io_out_valid !== 1'b1 || io_imem_req_valid !== 1'b0)
            begin n_bad++; $display("FAIL full_before_reset: out_valid %b req_valid %b expected 1 0", io_out_valid, io_imem_req_valid); end
        reset = 1'b1;
        #1;
        n_cmp++; if (io_out_valid !== 1'b0) begin n_bad++; $display("FAIL async_reset_out: got %b expected 0", io_out_valid); end
        do_reset();
        lat = 1; mem_rdy = 1; out_rdy = 1;
        tick();
        n_cmp++; if (!obs_req_fire || obs_addr !== RST_PC)
            begin n_bad++; $display("FAIL post_reset_addr: fire %b addr %h expected %h", obs_req_fire, obs_addr, RST_PC); end
        model_adv();
    endtask

    task automatic test_random();
        int nout;
        do_reset();
        nout = 0; lat = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) lat = $urandom_range(1, 4);
            mem_rdy   = ($urandom_range(0, 3) != 0);
            out_rdy   = ($urandom_range(0, 3) != 0);
            redir     = ($urandom_range(0, 19) == 0);
            redir_tgt = $urandom;
            tick();
            if (obs_redir) begin
                n_cmp++; if (obs_req_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_redir_suppress c%0d: got %b expected 0", i, obs_req_valid); end
            end
            if (obs_req_fire) begin
                n_cmp++; if (obs_addr !== m_req_pc) begin n_bad++; $display("FAIL rnd_req_addr c%0d: got %h expected %h", i, obs_addr, m_req_pc); end
            end
            if (obs_out_fire) begin
                n_cmp++;
                if (obs_pc !== m_out_pc || obs_instr !== mem_word(m_out_pc))
                    begin n_bad++; $display("FAIL rnd_out c%0d: pc %h instr %h expected pc %h instr %h", i, obs_pc, obs_instr, m_out_pc, mem_word(m_out_pc)); end
                nout++;
            end
            model_adv();
        end
        n_cmp++; if (nout < 300) begin n_bad++; $display("FAIL rnd_liveness: got %0d outputs expected >= 300", nout); end
    endtask

    initial begin
        io_imem_req_ready = 1'b0; io_imem_resp_valid = 1'b0; io_imem_resp_data = '0;
        io_redirect_valid = 1'b0; io_redirect_target = '0; io_out_ready = 1'b0;
        cyc = 0; last_due = 0; lat = 1;
        mem_rdy = 0; out_rdy = 0; redir = 0; redir_tgt = '0;
        test_reset();
        test_backpressure();
        test_redirect();
        test_collide();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
